// File: rtl/scanchain_cmd_assembler.sv
// Assembles a byte stream (header, address bytes, payload bytes) into one scan-write command
// and holds it on a valid/ready interface until the scan writer takes it.
module scanchain_cmd_assembler #(
  parameter int unsigned ADDR_BITS      = 12,
  parameter int unsigned PAYLOAD_BITS   = 169,
  parameter int unsigned TIMEOUT_CLOCKS = 1_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    write_valid,
  input  logic                    write_ready,
  output logic [ADDR_BITS-1:0]    write_addr,
  output logic [PAYLOAD_BITS-1:0] write_payload,
  output logic                    write_reset,
  output logic                    busy,
  output logic [7:0]              err_count
);

  localparam int unsigned ADDR_BYTES    = (ADDR_BITS + 7) / 8;
  localparam int unsigned PAYLOAD_BYTES = (PAYLOAD_BITS + 7) / 8;
  localparam int unsigned ADDR_EXT      = ADDR_BYTES * 8;
  localparam int unsigned PAYLOAD_EXT   = PAYLOAD_BYTES * 8;
  localparam int unsigned MAX_BYTES     = (PAYLOAD_BYTES > ADDR_BYTES) ? PAYLOAD_BYTES
                                                                       : ADDR_BYTES;
  localparam int unsigned IDX_W         = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int unsigned TMO_W         = (TIMEOUT_CLOCKS > 1) ? $clog2(TIMEOUT_CLOCKS) : 1;

  typedef enum logic [1:0] {StHeader, StAddr, StPayload, StIssue} state_e;

  state_e                  r_state, w_state_next;
  logic [IDX_W-1:0]        r_idx, w_idx_next;
  logic [TMO_W-1:0]        r_tmo, w_tmo_next;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [PAYLOAD_BITS-1:0] r_payload;
  logic                    r_wreset;
  logic [7:0]              r_err;

  logic                    w_accept;
  logic                    w_hdr_load;
  logic                    w_addr_load;
  logic                    w_pl_load;
  logic                    w_err_inc;
  logic                    w_tmo_hit;
  logic [IDX_W+2:0]        w_shift;

  assign rx_ready      = (r_state != StIssue);
  assign write_valid   = (r_state == StIssue);
  assign busy          = (r_state != StHeader);
  assign write_addr    = r_addr;
  assign write_payload = r_payload;
  assign write_reset   = r_wreset;
  assign err_count     = r_err;

  assign w_accept  = rx_valid && rx_ready;
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CLOCKS - 1));
  assign w_shift   = {r_idx, 3'b000};

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_tmo_next   = r_tmo;
    w_hdr_load   = 1'b0;
    w_addr_load  = 1'b0;
    w_pl_load    = 1'b0;
    w_err_inc    = 1'b0;
    unique case (r_state)
      StHeader: begin
        if (w_accept) begin
          if (rx_data[7:1] == 7'b1010101) begin
            w_hdr_load   = 1'b1;
            w_idx_next   = '0;
            w_tmo_next   = '0;
            w_state_next = StAddr;
          end else begin
            w_err_inc = 1'b1;
          end
        end
      end
      StAddr: begin
        // An accepted byte takes priority over a timeout expiring in the same cycle.
        if (w_accept) begin
          w_addr_load = 1'b1;
          w_tmo_next  = '0;
          if (r_idx == IDX_W'(ADDR_BYTES - 1)) begin
            w_idx_next   = '0;
            w_state_next = StPayload;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end else if (w_tmo_hit) begin
          w_err_inc    = 1'b1;
          w_tmo_next   = '0;
          w_idx_next   = '0;
          w_state_next = StHeader;
        end else begin
          w_tmo_next = r_tmo + TMO_W'(1);
        end
      end
      StPayload: begin
        if (w_accept) begin
          w_pl_load  = 1'b1;
          w_tmo_next = '0;
          if (r_idx == IDX_W'(PAYLOAD_BYTES - 1)) begin
            w_idx_next   = '0;
            w_state_next = StIssue;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end else if (w_tmo_hit) begin
          w_err_inc    = 1'b1;
          w_tmo_next   = '0;
          w_idx_next   = '0;
          w_state_next = StHeader;
        end else begin
          w_tmo_next = r_tmo + TMO_W'(1);
        end
      end
      StIssue: begin
        if (write_ready) begin
          w_state_next = StHeader;
        end
      end
      default: w_state_next = StHeader;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StHeader;
      r_idx     <= '0;
      r_tmo     <= '0;
      r_addr    <= '0;
      r_payload <= '0;
      r_wreset  <= 1'b0;
      r_err     <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_tmo   <= w_tmo_next;
      if (w_hdr_load) begin
        r_wreset <= rx_data[0];
      end
      // Byte lanes past the field width fall off in the final truncation.
      if (w_addr_load) begin
        r_addr <= ADDR_BITS'((ADDR_EXT'(r_addr) & ~(ADDR_EXT'(8'hFF) << w_shift))
                             | (ADDR_EXT'(rx_data) << w_shift));
      end
      if (w_pl_load) begin
        r_payload <= PAYLOAD_BITS'((PAYLOAD_EXT'(r_payload) & ~(PAYLOAD_EXT'(8'hFF) << w_shift))
                                   | (PAYLOAD_EXT'(rx_data) << w_shift));
      end
      if (w_err_inc && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_scanchain_cmd_assembler.sv
// Directed bench for scanchain_cmd_assembler, built with a 16-cycle inter-byte timeout.
module tb_scanchain_cmd_assembler;

  localparam int unsigned AB = 12;
  localparam int unsigned PB = 169;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          write_valid;
  logic          write_ready;
  logic [AB-1:0] write_addr;
  logic [PB-1:0] write_payload;
  logic          write_reset;
  logic          busy;
  logic [7:0]    err_count;

  int total = 0;
  int bad   = 0;

  logic [175:0]  exp_ext;
  logic [PB-1:0] exp_pl;
  logic          ok;

  always #5 clk = ~clk;

  scanchain_cmd_assembler #(
    .ADDR_BITS     (AB),
    .PAYLOAD_BITS  (PB),
    .TIMEOUT_CLOCKS(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .write_valid  (write_valid),
    .write_ready  (write_ready),
    .write_addr   (write_addr),
    .write_payload(write_payload),
    .write_reset  (write_reset),
    .busy         (busy),
    .err_count    (err_count)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte for one cycle; rx_valid is left high for back-to-back streaming.
  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
  endtask

  task automatic payload_bytes(input logic [7:0] base);
    exp_ext = '0;
    for (int k = 0; k < 22; k++) begin
      if (k == 21) chk("wv_before_last", write_valid, 1'b0);
      exp_ext[k*8 +: 8] = base + 8'(k);
      put(base + 8'(k));
    end
    rx_valid = 1'b0;
    exp_pl = exp_ext[PB-1:0];
  endtask

  task automatic handshake();
    write_ready = 1'b1;
    tick();
    write_ready = 1'b0;
    chk("hs_wv", write_valid, 1'b0);
    chk("hs_rx_ready", rx_ready, 1'b1);
    chk("hs_busy", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    write_ready = 1'b0;
    repeat (3) tick();
    chk("rst_wv", write_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_count, 8'd0);
    chk("rst_addr", write_addr, 12'h000);
    chk("rst_payload", write_payload, '0);
    chk("rst_wreset", write_reset, 1'b0);
    reset = 1'b0;
    chk("rst_rx_ready", rx_ready, 1'b1);

    // Reset mid-payload abandons the frame silently.
    put(8'hAB); put(8'h34); put(8'h02);
    for (int k = 0; k < 10; k++) put(8'(k + 1));
    rx_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ok = 1'b1;
    repeat (30) begin
      tick();
      if (write_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("abandon_no_wv", ok, 1'b1);
    chk("abandon_err", err_count, 8'd0);

    // Basic full frame.
    put(8'hAB); put(8'h34); put(8'h02);
    payload_bytes(8'h01);
    chk("f1_wv", write_valid, 1'b1);
    chk("f1_wreset", write_reset, 1'b1);
    chk("f1_addr", write_addr, 12'h234);
    chk("f1_pl_lo", write_payload[7:0], 8'h01);
    chk("f1_pl_top", write_payload[168], 1'b0);
    chk("f1_pl", write_payload, exp_pl);
    chk("f1_rx_ready", rx_ready, 1'b0);
    chk("f1_busy", busy, 1'b1);

    // Long back-pressure from the scan writer.
    ok = 1'b1;
    repeat (500) begin
      tick();
      if (write_valid !== 1'b1 || rx_ready !== 1'b0 || write_addr !== 12'h234 ||
          write_payload !== exp_pl || write_reset !== 1'b1) ok = 1'b0;
    end
    chk("hold_stable", ok, 1'b1);
    handshake();

    // Bad headers, then a frame with write_reset clear and truncated address.
    put(8'h00); chk("bad0_busy", busy, 1'b0);
    put(8'hFF); chk("bad1_busy", busy, 1'b0);
    put(8'h55); chk("bad2_busy", busy, 1'b0);
    rx_valid = 1'b0;
    chk("bad_err3", err_count, 8'd3);
    put(8'hAA); put(8'hCD); put(8'hFF);
    payload_bytes(8'h40);
    chk("f2_wv", write_valid, 1'b1);
    chk("f2_wreset", write_reset, 1'b0);
    chk("f2_addr", write_addr, 12'hFCD);
    chk("f2_pl_lo", write_payload[7:0], 8'h40);
    chk("f2_pl_top", write_payload[168], 1'b1);
    chk("f2_pl", write_payload, exp_pl);
    handshake();

    // Inter-byte timeout fires after exactly TO idle cycles.
    put(8'hAB); put(8'h11);
    rx_valid = 1'b0;
    repeat (TO - 1) tick();
    chk("to_pre_busy", busy, 1'b1);
    chk("to_pre_err", err_count, 8'd3);
    tick();
    chk("to_busy", busy, 1'b0);
    chk("to_err", err_count, 8'd4);

    // A byte arriving in the expiring cycle wins over the timeout.
    put(8'hAB); put(8'h11);
    rx_valid = 1'b0;
    repeat (TO - 1) tick();
    put(8'h22);
    rx_valid = 1'b0;
    chk("race_busy", busy, 1'b1);
    chk("race_err", err_count, 8'd4);
    payload_bytes(8'h80);
    chk("f3_wv", write_valid, 1'b1);
    chk("f3_addr", write_addr, 12'h211);
    chk("f3_pl", write_payload, exp_pl);
    handshake();

    // Error counter saturation.
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    repeat (250) tick();
    chk("sat_254", err_count, 8'd254);
    repeat (50) tick();
    rx_valid = 1'b0;
    chk("sat_255", err_count, 8'd255);
    chk("sat_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
